// File: rtl/present_sched_pkg.sv
// Shared types and constants for the PRESENT core scheduler.
// present_sched.sv additionally honours the optional macro PRESENT_SCHED_PRIO0_EN.
package present_pkg;

  localparam int PRESENT_BLK_W = 64;
  localparam int PRESENT_KEY_W = 128;

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} sched_state_t;

  typedef logic [PRESENT_BLK_W-1:0] blk_t;
  typedef logic [PRESENT_KEY_W-1:0] key_t;

endpackage

// File: rtl/present_sched_if.sv
// Requester-side request/response bundle of the PRESENT scheduler.
// Requester i owns bits [i] of the vectors and slice [i*W +: W] of the operand buses.
interface present_sched_if #(
  parameter int N_REQ = 4,
  parameter int BLK_W = 64,
  parameter int KEY_W = 128
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*BLK_W-1:0] req_pt;
  logic [N_REQ*KEY_W-1:0] req_key;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [BLK_W-1:0]       rsp_ct;

  modport master (
    output req_valid, req_pt, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_ct
  );

  modport slave (
    input  req_valid, req_pt, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_ct
  );

endinterface

// File: rtl/present_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, searching cyclically.
// The caller owns and advances the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand [N];
  logic [N-1:0]  rot_req;

  // rot_req[k] is the request k positions after ptr (mod N).
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0] sum;
    assign sum         = {1'b0, ptr} + (IW+1)'(gi);
    assign cand[gi]    = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    assign rot_req[gi] = req[cand[gi]];
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        idx = cand[k];
      end
    end
    if (|req) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/present_sched.sv
// Round-robin scheduler sharing one PRESENT core among N_REQ requesters, one operation in flight.
// Optional macro PRESENT_SCHED_PRIO0_EN: requester 0 gets strict priority over the rotation.
module present_sched
  import present_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BLK_W = PRESENT_BLK_W,
  parameter int KEY_W = PRESENT_KEY_W
) (
  input  logic             clk,
  input  logic             reset,
  present_sched_if.slave   bus,
  output logic             core_start,
  output logic [BLK_W-1:0] core_pt,
  output logic [KEY_W-1:0] core_key,
  input  logic             core_eoc,
  input  logic [BLK_W-1:0] core_ct
);

  localparam int PTR_W = $clog2(N_REQ);

  sched_state_t     state_reg, state_next;
  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next, id_reg;
  logic [PTR_W-1:0] arb_idx, win_idx;
  logic [N_REQ-1:0] arb_req, arb_gnt, win_oh;
  logic             ptr_upd, accept;
  logic [BLK_W-1:0] core_pt_reg, rsp_ct_reg;
  logic [KEY_W-1:0] core_key_reg;
  logic [BLK_W-1:0] pt_slice  [N_REQ];
  logic [KEY_W-1:0] key_slice [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign pt_slice[gi]  = bus.req_pt[gi*BLK_W +: BLK_W];
    assign key_slice[gi] = bus.req_key[gi*KEY_W +: KEY_W];
  end

`ifdef PRESENT_SCHED_PRIO0_EN
  // Requester 0 bypasses the rotation and leaves the pointer untouched.
  assign arb_req = {bus.req_valid[N_REQ-1:1], 1'b0};
  assign win_oh  = bus.req_valid[0] ? N_REQ'(1) : arb_gnt;
  assign win_idx = bus.req_valid[0] ? '0 : arb_idx;
  assign ptr_upd = ~bus.req_valid[0];
`else
  assign arb_req = bus.req_valid;
  assign win_oh  = arb_gnt;
  assign win_idx = arb_idx;
  assign ptr_upd = 1'b1;
`endif

  rr_arbiter #(.N(N_REQ), .IW(PTR_W)) u_arb (
    .req (arb_req),
    .ptr (rr_ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign accept      = (state_reg == IDLE) && (|(bus.req_valid & win_oh));
  assign rr_ptr_next = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  always_comb begin
    state_next    = state_reg;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    core_start    = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = win_oh;
        if (accept) state_next = START;
      end
      START: begin
        core_start = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        if (core_eoc) state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid[id_reg] = 1'b1;
        if (bus.rsp_ready[id_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      id_reg       <= '0;
      core_pt_reg  <= '0;
      core_key_reg <= '0;
      rsp_ct_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        core_pt_reg  <= pt_slice[win_idx];
        core_key_reg <= key_slice[win_idx];
        id_reg       <= win_idx;
        if (ptr_upd) rr_ptr_reg <= rr_ptr_next;
      end
      if (state_reg == BUSY && core_eoc) begin
        rsp_ct_reg <= core_ct;
      end
    end
  end

  assign core_pt    = core_pt_reg;
  assign core_key   = core_key_reg;
  assign bus.rsp_ct = rsp_ct_reg;

endmodule

// File: tb/tb_present_sched.sv
// Self-checking bench for present_sched with a behavioural PRESENT-128 core and arbitration model.
module tb_present_sched;
  import present_pkg::*;

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic        clk;
  logic        reset;
  logic        core_start;
  blk_t        core_pt;
  key_t        core_key;
  logic        core_eoc;
  blk_t        core_ct;

  present_sched_if #(.N_REQ(4), .BLK_W(64), .KEY_W(128)) bus ();

  present_sched #(.N_REQ(4), .BLK_W(64), .KEY_W(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_start (core_start),
    .core_pt    (core_pt),
    .core_key   (core_key),
    .core_eoc   (core_eoc),
    .core_ct    (core_ct)
  );

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   mptr    = 0;
  int   core_lat = 2;
  bit   core_manual = 1'b0;
  blk_t pt_arr  [4];
  key_t key_arr [4];
  logic model_eoc, spur_eoc;
  blk_t model_ct, spur_ct;

  assign core_eoc = model_eoc | spur_eoc;
  assign core_ct  = spur_eoc ? spur_ct : model_ct;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PRESENT-128 encryption.
  function automatic blk_t present128(input blk_t pt, input key_t key);
    blk_t s, t;
    key_t k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[127:64];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
      t = '0;
      for (int b = 0; b < 63; b++) t[(b * 16) % 63] = s[b];
      t[63] = s[63];
      s = t;
      k = {k[66:0], k[127:67]};
      k[127:124] = SBOX[k[127:124]];
      k[123:120] = SBOX[k[123:120]];
      k[66:62]   = k[66:62] ^ 5'(r);
    end
    return s ^ k[127:64];
  endfunction

  function automatic int model_win(input logic [3:0] m, input int p);
`ifdef PRESENT_SCHED_PRIO0_EN
    if (m[0]) return 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  function automatic int model_next_ptr(input int w, input int p);
`ifdef PRESENT_SCHED_PRIO0_EN
    if (w == 0) return p;
`endif
    return (w + 1) % 4;
  endfunction

  // Behavioural core: start seen in START, eoc after core_lat extra BUSY cycles.
  initial begin : core_model
    blk_t ct_v;
    int   lat_v;
    model_eoc = 1'b0;
    model_ct  = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1 && !core_manual) begin
        ct_v  = present128(core_pt, core_key);
        lat_v = core_lat;
        @(posedge clk); #1;
        repeat (lat_v) begin @(posedge clk); #1; end
        model_eoc = 1'b1;
        model_ct  = ct_v;
        @(posedge clk); #1;
        model_eoc = 1'b0;
        model_ct  = {$urandom, $urandom};
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pack();
    for (int i = 0; i < 4; i++) begin
      bus.req_pt[i*64 +: 64]    = pt_arr[i];
      bus.req_key[i*128 +: 128] = key_arr[i];
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 4; i++) begin
      pt_arr[i]  = {$urandom, $urandom};
      key_arr[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Runs one request/response exchange and reports what was observed.
  task automatic do_op(input logic [3:0] mask, output logic [3:0] g, output logic st,
                       output logic [3:0] rr_after, output blk_t cpt, output key_t ckey,
                       output logic [3:0] rv, output blk_t ct);
    g = '0; st = 1'b0; rr_after = 'x; cpt = 'x; ckey = 'x; rv = '0; ct = 'x;
    pack();
    bus.req_valid = mask;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready != 0) break;
      tick();
    end
    g = bus.req_ready;
    if (g == 0) begin
      bus.req_valid = '0;
      return;
    end
    tick();
    bus.req_valid = mask & ~g;
    st = core_start; rr_after = bus.req_ready; cpt = core_pt; ckey = core_key;
    for (int i = 0; i < 60; i++) begin
      if (bus.rsp_valid != 0) break;
      tick();
    end
    rv = bus.rsp_valid;
    ct = bus.rsp_ct;
    bus.rsp_ready = rv;
    tick();
    bus.rsp_ready = '0;
    bus.req_valid = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    spur_eoc = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    mptr = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    vec_cnt++; if (bus.req_ready !== 4'b0) begin err_cnt++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    vec_cnt++; if (bus.rsp_valid !== 4'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    vec_cnt++; if (core_start !== 1'b0) begin err_cnt++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    vec_cnt++; if (core_pt !== 64'h0) begin err_cnt++; $display("FAIL reset_core_pt: got %h want 0", core_pt); end
    vec_cnt++; if (core_key !== 128'h0) begin err_cnt++; $display("FAIL reset_core_key: got %h want 0", core_key); end
    vec_cnt++; if (bus.rsp_ct !== 64'h0) begin err_cnt++; $display("FAIL reset_rsp_ct: got %h want 0", bus.rsp_ct); end
    $display("reset: req_ready=%b rsp_valid=%b rsp_ct=%h", bus.req_ready, bus.rsp_valid, bus.rsp_ct);
  endtask

  task automatic test_single();
    logic [3:0] g, rr_after, rv;
    logic st;
    blk_t cpt, ct;
    key_t ckey;
    for (int i = 0; i < 4; i++) begin pt_arr[i] = '0; key_arr[i] = '0; end
    core_lat = 3;
    do_op(4'b0100, g, st, rr_after, cpt, ckey, rv, ct);
    mptr = model_next_ptr(2, mptr);
    vec_cnt++; if (g !== 4'b0100) begin err_cnt++; $display("FAIL single_grant: got %b want 0100", g); end
    vec_cnt++; if (st !== 1'b1) begin err_cnt++; $display("FAIL single_start: got %b want 1", st); end
    vec_cnt++; if (rr_after !== 4'b0) begin err_cnt++; $display("FAIL single_ready_drop: got %b want 0000", rr_after); end
    vec_cnt++; if (rv !== 4'b0100) begin err_cnt++; $display("FAIL single_rsp_valid: got %b want 0100", rv); end
    vec_cnt++; if (ct !== 64'h96db702a2e6900af) begin err_cnt++; $display("FAIL single_ct: got %h want 96db702a2e6900af", ct); end
    $display("single: grant=%b rsp_valid=%b ct=%h", g, rv, ct);
  endtask

  task automatic test_fairness();
    logic [3:0] g, rr_after, rv, eg;
    logic st;
    blk_t cpt, ct, ect;
    key_t ckey;
    int w;
    apply_reset();
    randomize_ops();
    for (int n = 0; n < 5; n++) begin
      core_lat = $urandom_range(0, 4);
      w   = model_win(4'b1111, mptr);
      eg  = 4'b0001 << w;
      ect = present128(pt_arr[w], key_arr[w]);
      do_op(4'b1111, g, st, rr_after, cpt, ckey, rv, ct);
      mptr = model_next_ptr(w, mptr);
      vec_cnt++; if (g !== eg) begin err_cnt++; $display("FAIL fair_grant[%0d]: got %b want %b", n, g, eg); end
      vec_cnt++; if (rv !== eg) begin err_cnt++; $display("FAIL fair_rsp_valid[%0d]: got %b want %b", n, rv, eg); end
      vec_cnt++; if (ct !== ect) begin err_cnt++; $display("FAIL fair_ct[%0d]: got %h want %h", n, ct, ect); end
      $display("fairness op %0d: grant=%b rsp_valid=%b ct=%h", n, g, rv, ct);
      pt_arr[w] = {$urandom, $urandom};
    end
  endtask

  task automatic test_random();
    logic [3:0] g, rr_after, rv, eg, mask;
    logic st;
    blk_t cpt, ct, ect;
    key_t ckey;
    int w;
    for (int n = 0; n < 20; n++) begin
      randomize_ops();
      mask     = 4'($urandom_range(1, 15));
      core_lat = $urandom_range(0, 4);
      w   = model_win(mask, mptr);
      eg  = 4'b0001 << w;
      ect = present128(pt_arr[w], key_arr[w]);
      do_op(mask, g, st, rr_after, cpt, ckey, rv, ct);
      mptr = model_next_ptr(w, mptr);
      vec_cnt++; if (g !== eg) begin err_cnt++; $display("FAIL rand_grant[%0d]: got %b want %b", n, g, eg); end
      vec_cnt++; if (st !== 1'b1) begin err_cnt++; $display("FAIL rand_start[%0d]: got %b want 1", n, st); end
      vec_cnt++; if (rr_after !== 4'b0) begin err_cnt++; $display("FAIL rand_ready_busy[%0d]: got %b want 0000", n, rr_after); end
      vec_cnt++; if (cpt !== pt_arr[w]) begin err_cnt++; $display("FAIL rand_core_pt[%0d]: got %h want %h", n, cpt, pt_arr[w]); end
      vec_cnt++; if (ckey !== key_arr[w]) begin err_cnt++; $display("FAIL rand_core_key[%0d]: got %h want %h", n, ckey, key_arr[w]); end
      vec_cnt++; if (rv !== eg) begin err_cnt++; $display("FAIL rand_rsp_valid[%0d]: got %b want %b", n, rv, eg); end
      vec_cnt++; if (ct !== ect) begin err_cnt++; $display("FAIL rand_ct[%0d]: got %h want %h", n, ct, ect); end
      $display("random op %0d: mask=%b grant=%b ct=%h", n, mask, g, ct);
    end
  endtask

  task automatic test_backpressure();
    blk_t ect;
    logic [3:0] eg;
    int w;
    randomize_ops();
    pack();
    core_lat = 1;
    ect = present128(pt_arr[1], key_arr[1]);
    bus.req_valid = 4'b0010;
    #1;
    vec_cnt++; if (bus.req_ready !== 4'b0010) begin err_cnt++; $display("FAIL bp_grant: got %b want 0010", bus.req_ready); end
    mptr = model_next_ptr(1, mptr);
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 60; i++) begin
      if (bus.rsp_valid != 0) break;
      tick();
    end
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1101;
    for (int c = 0; c < 20; c++) begin
      #1;
      vec_cnt++; if (bus.rsp_valid !== 4'b0010) begin err_cnt++; $display("FAIL bp_rsp_valid[%0d]: got %b want 0010", c, bus.rsp_valid); end
      vec_cnt++; if (bus.rsp_ct !== ect) begin err_cnt++; $display("FAIL bp_rsp_ct[%0d]: got %h want %h", c, bus.rsp_ct, ect); end
      vec_cnt++; if (bus.req_ready !== 4'b0) begin err_cnt++; $display("FAIL bp_req_ready[%0d]: got %b want 0000", c, bus.req_ready); end
      tick();
    end
    bus.rsp_ready = 4'b0010;
    #1;
    vec_cnt++; if (bus.req_ready !== 4'b0) begin err_cnt++; $display("FAIL bp_bubble: got %b want 0000", bus.req_ready); end
    tick();
    bus.rsp_ready = '0;
    w  = model_win(4'b1111, mptr);
    eg = 4'b0001 << w;
    vec_cnt++; if (bus.rsp_valid !== 4'b0) begin err_cnt++; $display("FAIL bp_rsp_clear: got %b want 0000", bus.rsp_valid); end
    vec_cnt++; if (bus.req_ready !== eg) begin err_cnt++; $display("FAIL bp_next_grant: got %b want %b", bus.req_ready, eg); end
    bus.req_valid = '0;
    #1;
    $display("backpressure: held 20 cycles ct=%h next_grant=%b", ect, eg);
  endtask

  task automatic test_reset_busy();
    logic [3:0] g, rr_after, rv, eg;
    logic st;
    blk_t cpt, ct, ect;
    key_t ckey;
    logic seen;
    int w;
    randomize_ops();
    pack();
    core_lat = 5;
    bus.req_valid = 4'b1000;
    #1;
    vec_cnt++; if (bus.req_ready !== 4'b1000) begin err_cnt++; $display("FAIL rb_grant: got %b want 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mptr = 0;
    vec_cnt++; if (bus.rsp_valid !== 4'b0) begin err_cnt++; $display("FAIL rb_rsp_valid: got %b want 0000", bus.rsp_valid); end
    vec_cnt++; if (core_pt !== 64'h0) begin err_cnt++; $display("FAIL rb_core_pt: got %h want 0", core_pt); end
    vec_cnt++; if (core_start !== 1'b0) begin err_cnt++; $display("FAIL rb_core_start: got %b want 0", core_start); end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.rsp_valid != 0) seen = 1'b1;
    end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL rb_lost_result: got rsp %b want none", seen); end
    core_lat = 2;
    randomize_ops();
    w   = model_win(4'b1111, mptr);
    eg  = 4'b0001 << w;
    ect = present128(pt_arr[w], key_arr[w]);
    do_op(4'b1111, g, st, rr_after, cpt, ckey, rv, ct);
    mptr = model_next_ptr(w, mptr);
    vec_cnt++; if (g !== eg) begin err_cnt++; $display("FAIL rb_after_grant: got %b want %b", g, eg); end
    vec_cnt++; if (ct !== ect) begin err_cnt++; $display("FAIL rb_after_ct: got %h want %h", ct, ect); end
    $display("reset_busy: post-reset grant=%b ct=%h", g, ct);
  endtask

  task automatic test_spurious_eoc();
    blk_t ect;
    randomize_ops();
    pack();
    core_manual = 1'b1;
    spur_ct  = {$urandom, $urandom};
    spur_eoc = 1'b1;
    tick();
    spur_eoc = 1'b0;
    vec_cnt++; if (bus.rsp_valid !== 4'b0) begin err_cnt++; $display("FAIL sp_idle_rsp: got %b want 0000", bus.rsp_valid); end
    ect = present128(pt_arr[0], key_arr[0]);
    bus.req_valid = 4'b0001;
    spur_eoc = 1'b1;
    #1;
    vec_cnt++; if (bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL sp_grant: got %b want 0001", bus.req_ready); end
    mptr = model_next_ptr(0, mptr);
    tick();
    bus.req_valid = '0;
    vec_cnt++; if (core_start !== 1'b1) begin err_cnt++; $display("FAIL sp_start: got %b want 1", core_start); end
    tick();
    spur_eoc = 1'b0;
    vec_cnt++; if (bus.rsp_valid !== 4'b0) begin err_cnt++; $display("FAIL sp_start_eoc: got %b want 0000", bus.rsp_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      vec_cnt++; if (bus.rsp_valid !== 4'b0) begin err_cnt++; $display("FAIL sp_busy_wait[%0d]: got %b want 0000", c, bus.rsp_valid); end
    end
    spur_ct  = ect;
    spur_eoc = 1'b1;
    tick();
    spur_eoc = 1'b0;
    spur_ct  = {$urandom, $urandom};
    vec_cnt++; if (bus.rsp_valid !== 4'b0001) begin err_cnt++; $display("FAIL sp_rsp_valid: got %b want 0001", bus.rsp_valid); end
    vec_cnt++; if (bus.rsp_ct !== ect) begin err_cnt++; $display("FAIL sp_rsp_ct: got %h want %h", bus.rsp_ct, ect); end
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;
    core_manual = 1'b0;
    $display("spurious_eoc: rsp_ct=%h", ect);
  endtask

`ifdef PRESENT_SCHED_PRIO0_EN
  task automatic test_prio0();
    logic [3:0] g, rr_after, rv, eg, mask;
    logic st;
    blk_t cpt, ct;
    key_t ckey;
    int w;
    for (int n = 0; n < 7; n++) begin
      randomize_ops();
      mask = (n < 4) ? 4'b1111 : 4'b1110;
      core_lat = $urandom_range(0, 3);
      w  = model_win(mask, mptr);
      eg = 4'b0001 << w;
      do_op(mask, g, st, rr_after, cpt, ckey, rv, ct);
      mptr = model_next_ptr(w, mptr);
      vec_cnt++; if (g !== eg) begin err_cnt++; $display("FAIL prio_grant[%0d]: got %b want %b", n, g, eg); end
      $display("prio0 op %0d: mask=%b grant=%b", n, mask, g);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    spur_eoc = 1'b0;
    spur_ct  = '0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_pt    = '0;
    bus.req_key   = '0;
    test_reset();
    test_single();
    test_fairness();
    test_random();
    test_backpressure();
    test_reset_busy();
    test_spurious_eoc();
`ifdef PRESENT_SCHED_PRIO0_EN
    test_prio0();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
